// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/DEAD control, step timing, direction filter,
// per-frame collision evaluation, length and score bookkeeping (clk_d domain).
module snake_game_ctrl #(
    parameter int TICK_FRAMES = 6,
    parameter int INIT_LEN    = 3,
    parameter int MAX_LEN     = 11,
    parameter int SCORE_W     = 8
) (
    input  logic               clk_d,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         dir_req,
    input  logic               frame_start,
    input  logic               hit_wall,
    input  logic               hit_self,
    input  logic               hit_apple,
    output logic               step,
    output logic [3:0]         dir_cur,
    output logic [3:0]         len,
    output logic               apple_respawn,
    output logic               game_over,
    output logic               playing,
    output logic [SCORE_W-1:0] score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;

    localparam logic [3:0] DIR_RIGHT = 4'b1000;
    localparam logic [3:0] LEN_INIT  = 4'(INIT_LEN);
    localparam logic [3:0] LEN_MAX   = 4'(MAX_LEN);
    localparam logic [5:0] FCNT_LAST = 6'(TICK_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [1:0] state;
    logic [3:0] dir_pend;
    logic [5:0] fcnt;
    logic       wall_s, self_s, apple_s;
    logic       start_q;

    logic       start_rise;
    logic       wall_e, self_e, apple_e;
    logic [3:0] dir_rev;
    logic       dir_onehot;
    logic       dir_ok;

    assign start_rise = start & ~start_q;

    // hits coincident with frame_start take part in that frame's evaluation
    assign wall_e  = wall_s  | hit_wall;
    assign self_e  = self_s  | hit_self;
    assign apple_e = apple_s | hit_apple;

    // swap up<->down and left<->right
    assign dir_rev    = {dir_cur[2], dir_cur[3], dir_cur[0], dir_cur[1]};
    assign dir_onehot = (dir_req != 4'b0000) && ((dir_req & (dir_req - 4'd1)) == 4'b0000);
    assign dir_ok     = dir_onehot && (dir_req != dir_rev);

    always_ff @(posedge clk_d) begin
        if (reset) begin
            state         <= S_IDLE;
            step          <= 1'b0;
            apple_respawn <= 1'b0;
            game_over     <= 1'b0;
            playing       <= 1'b0;
            score         <= '0;
            len           <= LEN_INIT;
            dir_cur       <= DIR_RIGHT;
            dir_pend      <= DIR_RIGHT;
            fcnt          <= 6'd0;
            wall_s        <= 1'b0;
            self_s        <= 1'b0;
            apple_s       <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            start_q       <= start;
            step          <= 1'b0;
            apple_respawn <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        state    <= S_PLAY;
                        playing  <= 1'b1;
                        score    <= '0;
                        len      <= LEN_INIT;
                        dir_cur  <= DIR_RIGHT;
                        dir_pend <= DIR_RIGHT;
                        fcnt     <= 6'd0;
                        wall_s   <= 1'b0;
                        self_s   <= 1'b0;
                        apple_s  <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (dir_ok) begin
                        dir_pend <= dir_req;
                    end
                    if (frame_start) begin
                        wall_s  <= 1'b0;
                        self_s  <= 1'b0;
                        apple_s <= 1'b0;
                        if (wall_e || self_e) begin
                            state     <= S_DEAD;
                            playing   <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            if (apple_e) begin
                                apple_respawn <= 1'b1;
                                if (score != SCORE_MAX) begin
                                    score <= score + SCORE_W'(1);
                                end
                                if (len < LEN_MAX) begin
                                    len <= len + 4'd1;
                                end
                            end
                            // dir_cur takes the request accepted before this cycle
                            if (fcnt == FCNT_LAST) begin
                                fcnt    <= 6'd0;
                                dir_cur <= dir_pend;
                                step    <= 1'b1;
                            end else begin
                                fcnt <= fcnt + 6'd1;
                            end
                        end
                    end else begin
                        wall_s  <= wall_e;
                        self_s  <= self_e;
                        apple_s <= apple_e;
                    end
                end
                S_DEAD: begin
                    if (start_rise) begin
                        state     <= S_IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    playing   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios plus random traffic, checked
// every cycle against a rule-level model of the game.
`timescale 1ns/1ps
module tb_snake_game_ctrl;

    localparam int TICK = 6;
    localparam int INIT = 3;
    localparam int MAXL = 11;

    logic       clk_d = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dir_req = 4'b0000;
    logic       frame_start = 1'b0;
    logic       hit_wall = 1'b0;
    logic       hit_self = 1'b0;
    logic       hit_apple = 1'b0;
    logic       step;
    logic [3:0] dir_cur;
    logic [3:0] len;
    logic       apple_respawn;
    logic       game_over;
    logic       playing;
    logic [7:0] score;

    snake_game_ctrl #(
        .TICK_FRAMES(TICK), .INIT_LEN(INIT), .MAX_LEN(MAXL), .SCORE_W(8)
    ) dut (
        .clk_d(clk_d), .reset(reset), .start(start), .dir_req(dir_req),
        .frame_start(frame_start), .hit_wall(hit_wall), .hit_self(hit_self),
        .hit_apple(hit_apple), .step(step), .dir_cur(dir_cur), .len(len),
        .apple_respawn(apple_respawn), .game_over(game_over),
        .playing(playing), .score(score)
    );

    always #20 clk_d = ~clk_d;

    int checks = 0;
    int errors = 0;
    int n_steps = 0;
    int n_resp = 0;

    // model: game phase as two booleans, counters as plain integers
    bit       m_play, m_dead;
    int       m_score, m_len, m_frames;
    bit [3:0] m_cur, m_pend;
    bit       seen_w, seen_s, seen_a, m_sq;
    bit       e_step, e_resp;

    function automatic bit [3:0] opposite(input bit [3:0] d);
        case (d)
            4'b0001: return 4'b0010;
            4'b0010: return 4'b0001;
            4'b0100: return 4'b1000;
            4'b1000: return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit rise;
        bit [3:0] old_pend;
        e_step = 0;
        e_resp = 0;
        if (reset) begin
            m_play = 0; m_dead = 0; m_score = 0; m_len = INIT;
            m_cur = 4'b1000; m_pend = 4'b1000; m_frames = 0;
            seen_w = 0; seen_s = 0; seen_a = 0; m_sq = 0;
            return;
        end
        rise = start && !m_sq;
        m_sq = start;
        if (!m_play && !m_dead) begin
            if (rise) begin
                m_play = 1; m_score = 0; m_len = INIT; m_frames = 0;
                m_cur = 4'b1000; m_pend = 4'b1000;
                seen_w = 0; seen_s = 0; seen_a = 0;
            end
        end else if (m_play) begin
            old_pend = m_pend;
            if ($countones(dir_req) == 1 && dir_req != opposite(m_cur))
                m_pend = dir_req;
            seen_w |= hit_wall;
            seen_s |= hit_self;
            seen_a |= hit_apple;
            if (frame_start) begin
                if (seen_w || seen_s) begin
                    m_play = 0;
                    m_dead = 1;
                end else begin
                    if (seen_a) begin
                        e_resp = 1;
                        if (m_score < 255) m_score++;
                        if (m_len < MAXL) m_len++;
                    end
                    m_frames++;
                    if (m_frames == TICK) begin
                        m_frames = 0;
                        e_step = 1;
                        m_cur = old_pend;
                    end
                end
                seen_w = 0; seen_s = 0; seen_a = 0;
            end
        end else if (rise) begin
            m_dead = 0;
        end
    endtask

    task automatic cyc(input bit fs, input bit hw, input bit hs, input bit ha,
                       input bit [3:0] dr);
        frame_start = fs; hit_wall = hw; hit_self = hs; hit_apple = ha;
        dir_req = dr;
        @(posedge clk_d);
        model_update();
        #1;
        check("step", step, e_step);
        check("apple_respawn", apple_respawn, e_resp);
        check("game_over", game_over, m_dead);
        check("playing", playing, m_play);
        check("score", score, m_score);
        check("len", len, m_len);
        check("dir_cur", dir_cur, m_cur);
        n_steps += int'(step);
        n_resp += int'(apple_respawn);
    endtask

    task automatic frame(input int gap, input bit [3:0] dr);
        for (int i = 0; i < gap; i++) cyc(0, 0, 0, 0, dr);
        cyc(1, 0, 0, 0, dr);
    endtask

    task automatic press();
        start = 1'b1;
        cyc(0, 0, 0, 0, 0);
        start = 1'b0;
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 4'b0001);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);

        // start, 12 quiet frames -> 2 steps
        press();
        n_steps = 0;
        for (int f = 0; f < 12; f++) frame($urandom_range(1, 4), 4'b0000);
        check("steps_12_frames", n_steps, 2);
        check("len_after_12", len, 3);

        // reversal held across a step, then up, then multi-hot ignored
        for (int f = 0; f < 7; f++) frame($urandom_range(1, 3), 4'b0100);
        check("dir_after_reverse", dir_cur, 4'b1000);
        cyc(0, 0, 0, 0, 4'b0001);
        for (int f = 0; f < 6; f++) frame($urandom_range(1, 3), 4'b0011);
        check("dir_after_up", dir_cur, 4'b0001);

        // 11 apples: length saturates at 11
        n_resp = 0;
        for (int a = 0; a < 11; a++) begin
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 1, 0);
            frame($urandom_range(0, 3), 4'b0000);
        end
        check("respawn_count", n_resp, 11);
        check("score_11", score, 11);
        check("len_sat", len, 11);

        // apple and wall in one frame -> death wins
        n_steps = 0;
        n_resp = 0;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        frame(1, 4'b0000);
        check("dead_go", game_over, 1);
        check("dead_score", score, 11);
        check("dead_no_resp", n_resp, 0);

        // DEAD ignores hits and frames
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, 4'b0100);
        check("dead_no_step", n_steps, 0);
        press();
        check("idle_go", game_over, 0);
        press();
        check("replay_score", score, 0);
        check("replay_len", len, 3);

        // hit_self with frame_start when fcnt=5 -> no step
        for (int f = 0; f < 5; f++) frame(1, 4'b0000);
        n_steps = 0;
        cyc(1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("self_no_step", n_steps, 0);
        check("self_dead", game_over, 1);

        // random traffic with occasional resets
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            else reset = 1'b0;
            if ($urandom_range(0, 29) == 0) start = ~start;
            cyc($urandom_range(0, 3) == 0,
                $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 2,
                $urandom_range(0, 9) == 0,
                4'($urandom_range(0, 15)));
        end
        reset = 1'b0;
        start = 1'b0;

        // reset mid-PLAY cancels a pending step/respawn
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
        press();
        for (int f = 0; f < 5; f++) frame(1, 4'b0001);
        cyc(0, 0, 0, 1, 0);
        reset = 1'b1;
        cyc(1, 0, 0, 0, 0);
        reset = 1'b0;
        check("rst_playing", playing, 0);
        check("rst_score", score, 0);
        check("rst_dir", dir_cur, 4'b1000);
        cyc(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
